elevator_call_latch: RTL and testbench

Input conditioning and request-latching stage that sits directly upstream of the `elevator` controller. It takes the raw cab buttons `f1..f3`, up-hall buttons `u1..u3`, down-hall buttons `d1..d3` and floor sensors `s1..s3`. It synchronizes and debounces each one, then turns every confirmed press into a sticky pending-request bit. The controller consumes the pending vectors plus single-cycle arrival pulses, and returns a clear request once a floor has been serviced.

---
 rtl/elevator_call_latch_pkg.sv | 44 ++++
 rtl/elevator_call_latch_if.sv | 25 ++
 rtl/elevator_call_latch_debounce.sv | 126 ++++++++++++
 rtl/elevator_call_latch.sv | 115 +++++++++++
 tb/tb_elevator_call_latch.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/elevator_call_latch_pkg.sv
// Shared elevator definitions: floor/clear-mask encodings, debounce state type
// and small decode helpers used by the call latch and the controller.
package elevator_pkg;

    localparam int NUM_FLOORS = 3;

    localparam logic [2:0] CLR_CAB = 3'b100;
    localparam logic [2:0] CLR_UP  = 3'b010;
    localparam logic [2:0] CLR_DN  = 3'b001;

    localparam logic [1:0] FLOOR_NONE = 2'd0;
    localparam logic [1:0] FLOOR_1    = 2'd1;
    localparam logic [1:0] FLOOR_2    = 2'd2;
    localparam logic [1:0] FLOOR_3    = 2'd3;

    typedef enum logic [1:0] {
        DB_LOW     = 2'd0,
        DB_CONF_HI = 2'd1,
        DB_HIGH    = 2'd2,
        DB_CONF_LO = 2'd3
    } db_state_t;

    // One-hot sensor vector to floor number; anything not exactly one-hot is "between floors".
    function automatic logic [1:0] encode_floor(input logic [NUM_FLOORS-1:0] sens);
        logic [1:0] floor_v;
        case (sens)
            3'b001:  floor_v = FLOOR_1;
            3'b010:  floor_v = FLOOR_2;
            3'b100:  floor_v = FLOOR_3;
            default: floor_v = FLOOR_NONE;
        endcase
        return floor_v;
    endfunction

    function automatic logic multi_hot(input logic [NUM_FLOORS-1:0] sens);
        logic multi_v;
        case (sens)
            3'b000, 3'b001, 3'b010, 3'b100: multi_v = 1'b0;
            default:                        multi_v = 1'b1;
        endcase
        return multi_v;
    endfunction

endpackage

// File: rtl/elevator_call_latch_if.sv
// Controller-facing bundle of the call latch: clear requests in, pending
// request vectors and floor status out.
interface elevator_call_latch_if;
    import elevator_pkg::*;

    logic                  clr_valid;
    logic [1:0]            clr_floor;
    logic [2:0]            clr_mask;
    logic [NUM_FLOORS-1:0] pend_f;
    logic [NUM_FLOORS-1:0] pend_u;
    logic [NUM_FLOORS-1:0] pend_d;
    logic [NUM_FLOORS-1:0] arrive;
    logic [1:0]            at_floor;
    logic                  sensor_err;

    modport master (
        output clr_valid, clr_floor, clr_mask,
        input  pend_f, pend_u, pend_d, arrive, at_floor, sensor_err
    );

    modport slave (
        input  clr_valid, clr_floor, clr_mask,
        output pend_f, pend_u, pend_d, arrive, at_floor, sensor_err
    );
endinterface

// File: rtl/elevator_call_latch_debounce.sv
// call_debounce: 2-flop synchronizer, optional debounce FSM (ELEVATOR_CALL_DEBOUNCE_EN)
// and rising-edge detector for one raw asynchronous input.
module call_debounce
    import elevator_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise
);

    logic sync1_r;
    logic sync2_r;
    logic level_s;
    logic prev_r;

    // Two-stage synchronizer for the asynchronous raw level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
        end
    end

`ifdef ELEVATOR_CALL_DEBOUNCE_EN
    localparam logic SINGLE_SAMPLE = (DEBOUNCE_CYCLES == 1);

    db_state_t        state_r;
    db_state_t        state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             reach_s;

    assign reach_s = ((cnt_r + CNT_W'(1)) == CNT_W'(DEBOUNCE_CYCLES));

    // Debounce state and sample counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= DB_LOW;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next state: a level change is accepted only after DEBOUNCE_CYCLES equal samples.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = '0;
        case (state_r)
            DB_LOW: begin
                if (sync2_r) begin
                    if (SINGLE_SAMPLE) begin
                        state_nxt_s = DB_HIGH;
                    end else begin
                        state_nxt_s = DB_CONF_HI;
                        cnt_nxt_s   = CNT_W'(1);
                    end
                end else begin
                    state_nxt_s = DB_LOW;
                end
            end
            DB_CONF_HI: begin
                if (!sync2_r) begin
                    state_nxt_s = DB_LOW;
                end else if (reach_s) begin
                    state_nxt_s = DB_HIGH;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            DB_HIGH: begin
                if (!sync2_r) begin
                    if (SINGLE_SAMPLE) begin
                        state_nxt_s = DB_LOW;
                    end else begin
                        state_nxt_s = DB_CONF_LO;
                        cnt_nxt_s   = CNT_W'(1);
                    end
                end else begin
                    state_nxt_s = DB_HIGH;
                end
            end
            DB_CONF_LO: begin
                if (sync2_r) begin
                    state_nxt_s = DB_HIGH;
                end else if (reach_s) begin
                    state_nxt_s = DB_LOW;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_nxt_s = DB_LOW;
            end
        endcase
    end

    assign level_s = (state_r == DB_HIGH) || (state_r == DB_CONF_LO);
`else
    localparam int unused_cfg = DEBOUNCE_CYCLES + CNT_W;

    assign level_s = sync2_r;
`endif

    // Previous debounced level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_r <= 1'b0;
        end else begin
            prev_r <= level_s;
        end
    end

    assign level = level_s;
    assign rise  = level_s & ~prev_r;

endmodule

// File: rtl/elevator_call_latch.sv
// elevator_call_latch: conditions 12 raw button/sensor inputs and latches sticky
// call requests for the controller. Debounce is built when ELEVATOR_CALL_DEBOUNCE_EN is defined.
module elevator_call_latch
    import elevator_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  f1,
    input  logic                  f2,
    input  logic                  f3,
    input  logic                  u1,
    input  logic                  u2,
    input  logic                  u3,
    input  logic                  d1,
    input  logic                  d2,
    input  logic                  d3,
    input  logic                  s1,
    input  logic                  s2,
    input  logic                  s3,
    elevator_call_latch_if.slave  bus
);

    logic [11:0]           raw_s;
    logic [11:0]           level_s;
    logic [11:0]           rise_s;
    logic [8:0]            btn_level_unused_s;
    logic [NUM_FLOORS-1:0] sens_s;
    logic [NUM_FLOORS-1:0] clr_sel_s;
    logic [NUM_FLOORS-1:0] clr_f_s;
    logic [NUM_FLOORS-1:0] clr_u_s;
    logic [NUM_FLOORS-1:0] clr_d_s;
    logic [NUM_FLOORS-1:0] pend_f_nxt_s;
    logic [NUM_FLOORS-1:0] pend_u_nxt_s;
    logic [NUM_FLOORS-1:0] pend_d_nxt_s;
    logic [1:0]            at_floor_nxt_s;
    logic                  multi_s;

    logic [NUM_FLOORS-1:0] pend_f_r;
    logic [NUM_FLOORS-1:0] pend_u_r;
    logic [NUM_FLOORS-1:0] pend_d_r;
    logic [NUM_FLOORS-1:0] arrive_r;
    logic [1:0]            at_floor_r;
    logic                  sensor_err_r;

    // Index map: [2:0] cab, [5:3] up, [8:6] down, [11:9] sensors; bit0 of each group is floor 1.
    assign raw_s = {s3, s2, s1, d3, d2, d1, u3, u2, u1, f3, f2, f1};

    for (genvar i = 0; i < 12; i++) begin : g_in
        call_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_db (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (raw_s[i]),
            .level(level_s[i]),
            .rise (rise_s[i])
        );
    end

    assign btn_level_unused_s = level_s[8:0];
    assign sens_s             = level_s[11:9];

    // Decode the controller's clear strobe into per-group bit masks.
    always_comb begin
        clr_sel_s = 3'b000;
        if (bus.clr_valid && (bus.clr_floor != FLOOR_NONE)) begin
            clr_sel_s = 3'b001 << (bus.clr_floor - 2'd1);
        end else begin
            clr_sel_s = 3'b000;
        end
        clr_f_s = ((bus.clr_mask & CLR_CAB) != 3'b000) ? clr_sel_s : 3'b000;
        clr_u_s = ((bus.clr_mask & CLR_UP)  != 3'b000) ? clr_sel_s : 3'b000;
        clr_d_s = ((bus.clr_mask & CLR_DN)  != 3'b000) ? clr_sel_s : 3'b000;
    end

    // Set is OR-ed in after the clear so a coincident press survives.
    always_comb begin
        pend_f_nxt_s   = (pend_f_r & ~clr_f_s) | rise_s[2:0];
        pend_u_nxt_s   = (pend_u_r & ~clr_u_s) | rise_s[5:3];
        pend_d_nxt_s   = (pend_d_r & ~clr_d_s) | rise_s[8:6];
        at_floor_nxt_s = encode_floor(sens_s);
        multi_s        = multi_hot(sens_s);
    end

    // Output registers: pending requests, arrival pulses, floor status, sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_f_r     <= 3'b000;
            pend_u_r     <= 3'b000;
            pend_d_r     <= 3'b000;
            arrive_r     <= 3'b000;
            at_floor_r   <= FLOOR_NONE;
            sensor_err_r <= 1'b0;
        end else begin
            pend_f_r     <= pend_f_nxt_s;
            pend_u_r     <= pend_u_nxt_s;
            pend_d_r     <= pend_d_nxt_s;
            arrive_r     <= rise_s[11:9];
            at_floor_r   <= at_floor_nxt_s;
            sensor_err_r <= sensor_err_r | multi_s;
        end
    end

    assign bus.pend_f     = pend_f_r;
    assign bus.pend_u     = pend_u_r;
    assign bus.pend_d     = pend_d_r;
    assign bus.arrive     = arrive_r;
    assign bus.at_floor   = at_floor_r;
    assign bus.sensor_err = sensor_err_r;

endmodule

// File: tb/tb_elevator_call_latch.sv
// Directed, table-driven bench for elevator_call_latch; expected latency follows
// whether ELEVATOR_CALL_DEBOUNCE_EN is defined.
module tb_elevator_call_latch;
    import elevator_pkg::*;

`ifdef ELEVATOR_CALL_DEBOUNCE_EN
    localparam int LAT = 7;
`else
    localparam int LAT = 3;
`endif
    localparam int W = LAT + 1;

    typedef struct {
        logic [2:0] f;
        logic [2:0] u;
        logic [2:0] d;
        logic [2:0] s;
        logic       cv;
        logic [1:0] cf;
        logic [2:0] cm;
        logic [2:0] ef;
        logic [2:0] eu;
        logic [2:0] ed;
        logic [1:0] ea;
        logic       ee;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [2:0] f_v;
    logic [2:0] u_v;
    logic [2:0] d_v;
    logic [2:0] s_v;
    int         n_cmp;
    int         n_err;
    vec_t       vecs [14];

    elevator_call_latch_if bus ();

    elevator_call_latch #(.DEBOUNCE_CYCLES(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .f1   (f_v[0]),
        .f2   (f_v[1]),
        .f3   (f_v[2]),
        .u1   (u_v[0]),
        .u2   (u_v[1]),
        .u3   (u_v[2]),
        .d1   (d_v[0]),
        .d2   (d_v[1]),
        .d3   (d_v[2]),
        .s1   (s_v[0]),
        .s2   (s_v[1]),
        .s3   (s_v[2]),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pend_f"},   {5'd0, bus.pend_f},   8'h00);
        check({tag, "_pend_u"},   {5'd0, bus.pend_u},   8'h00);
        check({tag, "_pend_d"},   {5'd0, bus.pend_d},   8'h00);
        check({tag, "_arrive"},   {5'd0, bus.arrive},   8'h00);
        check({tag, "_at_floor"}, {6'd0, bus.at_floor}, 8'h00);
        check({tag, "_err"},      {7'd0, bus.sensor_err}, 8'h00);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        f_v = 3'b010;
        u_v = 3'b000;
        d_v = 3'b000;
        s_v = 3'b000;
        bus.clr_valid = 1'b0;
        bus.clr_floor = 2'd0;
        bus.clr_mask  = 3'b000;

        //        f       u       d       s       cv    cf    cm      ef      eu      ed      ea    ee
        vecs[0]  = '{3'b010, 3'b000, 3'b000, 3'b000, 1'b0, 2'd0, 3'b000, 3'b010, 3'b000, 3'b000, 2'd0, 1'b0};
        vecs[1]  = '{3'b000, 3'b000, 3'b100, 3'b000, 1'b0, 2'd0, 3'b000, 3'b010, 3'b000, 3'b100, 2'd0, 1'b0};
        vecs[2]  = '{3'b100, 3'b000, 3'b000, 3'b000, 1'b0, 2'd0, 3'b000, 3'b110, 3'b000, 3'b100, 2'd0, 1'b0};
        vecs[3]  = '{3'b000, 3'b000, 3'b000, 3'b000, 1'b1, 2'd3, 3'b001, 3'b110, 3'b000, 3'b000, 2'd0, 1'b0};
        vecs[4]  = '{3'b000, 3'b000, 3'b000, 3'b000, 1'b1, 2'd2, 3'b100, 3'b100, 3'b000, 3'b000, 2'd0, 1'b0};
        vecs[5]  = '{3'b000, 3'b100, 3'b001, 3'b000, 1'b0, 2'd0, 3'b000, 3'b100, 3'b100, 3'b001, 2'd0, 1'b0};
        vecs[6]  = '{3'b000, 3'b000, 3'b000, 3'b000, 1'b1, 2'd0, 3'b111, 3'b100, 3'b100, 3'b001, 2'd0, 1'b0};
        vecs[7]  = '{3'b000, 3'b000, 3'b000, 3'b000, 1'b1, 2'd3, 3'b111, 3'b000, 3'b000, 3'b001, 2'd0, 1'b0};
        vecs[8]  = '{3'b000, 3'b000, 3'b000, 3'b010, 1'b0, 2'd0, 3'b000, 3'b000, 3'b000, 3'b001, 2'd2, 1'b0};
        vecs[9]  = '{3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 2'd0, 3'b000, 3'b000, 3'b000, 3'b001, 2'd0, 1'b0};
        vecs[10] = '{3'b000, 3'b000, 3'b000, 3'b001, 1'b0, 2'd0, 3'b000, 3'b000, 3'b000, 3'b001, 2'd1, 1'b0};
        vecs[11] = '{3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 2'd0, 3'b000, 3'b000, 3'b000, 3'b001, 2'd0, 1'b0};
        vecs[12] = '{3'b000, 3'b000, 3'b000, 3'b100, 1'b0, 2'd0, 3'b000, 3'b000, 3'b000, 3'b001, 2'd3, 1'b0};
        vecs[13] = '{3'b000, 3'b000, 3'b000, 3'b000, 1'b1, 2'd1, 3'b001, 3'b000, 3'b000, 3'b000, 2'd0, 1'b0};

        // Reset with f2 held, then count edges to the latch after release.
        tick(3);
        check_all_zero("in_reset");
        rst_n = 1'b1;
        tick(LAT - 1);
        check("f2_before_lat", {5'd0, bus.pend_f}, 8'h00);
        tick(1);
        check("f2_at_lat", {5'd0, bus.pend_f}, 8'h02);

        for (int i = 0; i < 14; i++) begin
            f_v = vecs[i].f;
            u_v = vecs[i].u;
            d_v = vecs[i].d;
            s_v = vecs[i].s;
            bus.clr_valid = vecs[i].cv;
            bus.clr_floor = vecs[i].cf;
            bus.clr_mask  = vecs[i].cm;
            tick(1);
            bus.clr_valid = 1'b0;
            tick(W - 1);
            check($sformatf("v%0d_pend_f", i),   {5'd0, bus.pend_f},     {5'd0, vecs[i].ef});
            check($sformatf("v%0d_pend_u", i),   {5'd0, bus.pend_u},     {5'd0, vecs[i].eu});
            check($sformatf("v%0d_pend_d", i),   {5'd0, bus.pend_d},     {5'd0, vecs[i].ed});
            check($sformatf("v%0d_at_floor", i), {6'd0, bus.at_floor},   {6'd0, vecs[i].ea});
            check($sformatf("v%0d_err", i),      {7'd0, bus.sensor_err}, {7'd0, vecs[i].ee});
        end

        // Glitch rejection on u1, then an accepted press.
`ifdef ELEVATOR_CALL_DEBOUNCE_EN
        u_v[0] = 1'b1;
        tick(3);
        u_v[0] = 1'b0;
        tick(W + 2);
        check("u1_glitch", {5'd0, bus.pend_u}, 8'h00);
        u_v[0] = 1'b1;
        tick(6);
        u_v[0] = 1'b0;
        tick(W);
        check("u1_press", {5'd0, bus.pend_u}, 8'h01);
`else
        u_v[0] = 1'b1;
        tick(1);
        u_v[0] = 1'b0;
        tick(W);
        check("u1_short_accept", {5'd0, bus.pend_u}, 8'h01);
`endif
        bus.clr_valid = 1'b1;
        bus.clr_floor = FLOOR_1;
        bus.clr_mask  = CLR_UP;
        tick(1);
        bus.clr_valid = 1'b0;
        check("u1_clear", {5'd0, bus.pend_u}, 8'h00);

        // Latch d3 and f3, clear only the down request at floor 3.
        f_v[2] = 1'b1;
        d_v[2] = 1'b1;
        tick(W);
        f_v[2] = 1'b0;
        d_v[2] = 1'b0;
        tick(W);
        bus.clr_valid = 1'b1;
        bus.clr_floor = FLOOR_3;
        bus.clr_mask  = CLR_DN;
        tick(1);
        bus.clr_valid = 1'b0;
        check("clr3_pend_d", {5'd0, bus.pend_d}, 8'h00);
        check("clr3_pend_f", {5'd0, bus.pend_f}, 8'h04);
        bus.clr_valid = 1'b1;
        bus.clr_mask  = CLR_CAB;
        tick(1);
        bus.clr_valid = 1'b0;
        check("clr3_cab", {5'd0, bus.pend_f}, 8'h00);

        // f1 rise lands on the same edge as a cab clear of floor 1: set wins.
        f_v[0] = 1'b1;
        tick(LAT - 1);
        check("f1_pre_set", {5'd0, bus.pend_f}, 8'h00);
        bus.clr_valid = 1'b1;
        bus.clr_floor = FLOOR_1;
        bus.clr_mask  = CLR_CAB;
        tick(1);
        bus.clr_valid = 1'b0;
        check("f1_set_wins", {5'd0, bus.pend_f}, 8'h01);
        bus.clr_valid = 1'b1;
        tick(1);
        bus.clr_valid = 1'b0;
        check("f1_clear_held", {5'd0, bus.pend_f}, 8'h00);
        tick(W);
        check("f1_held_once", {5'd0, bus.pend_f}, 8'h00);
        f_v[0] = 1'b0;
        tick(W);

        // Arrival pulse on s2, then a second sensor raises the error.
        s_v[1] = 1'b1;
        tick(LAT - 1);
        check("s2_arrive_pre", {5'd0, bus.arrive}, 8'h00);
        check("s2_at_pre", {6'd0, bus.at_floor}, 8'h00);
        tick(1);
        check("s2_arrive", {5'd0, bus.arrive}, 8'h02);
        check("s2_at", {6'd0, bus.at_floor}, 8'h02);
        tick(1);
        check("s2_arrive_end", {5'd0, bus.arrive}, 8'h00);
        check("s2_at_hold", {6'd0, bus.at_floor}, 8'h02);
        s_v[2] = 1'b1;
        tick(W);
        check("s23_at", {6'd0, bus.at_floor}, 8'h00);
        check("s23_err", {7'd0, bus.sensor_err}, 8'h01);
        s_v[2] = 1'b0;
        tick(W);
        check("s2_back_at", {6'd0, bus.at_floor}, 8'h02);
        check("err_sticky", {7'd0, bus.sensor_err}, 8'h01);
        s_v[1] = 1'b0;
        tick(W);

        // Fill every pending bit, then assert reset between clock edges.
        f_v = 3'b111;
        u_v = 3'b111;
        d_v = 3'b111;
        s_v = 3'b001;
        tick(W);
        f_v = 3'b000;
        u_v = 3'b000;
        d_v = 3'b000;
        tick(W);
        check("all_pend_f", {5'd0, bus.pend_f}, 8'h07);
        check("all_pend_u", {5'd0, bus.pend_u}, 8'h07);
        check("all_pend_d", {5'd0, bus.pend_d}, 8'h07);
        check("pre_rst_at", {6'd0, bus.at_floor}, 8'h01);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        tick(2);
        rst_n = 1'b1;
        tick(LAT - 1);
        check("post_rst_at_pre", {6'd0, bus.at_floor}, 8'h00);
        tick(2);
        check("post_rst_at", {6'd0, bus.at_floor}, 8'h01);
        check("post_rst_pend_f", {5'd0, bus.pend_f}, 8'h00);
        check("post_rst_err", {7'd0, bus.sensor_err}, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
